vec_add_acc: RTL and testbench
==============================

Name: vec_add_acc

Overview:
Multi-lane, pipelined signed adder/subtractor with a per-lane running accumulator. It is the successor of the single-lane adder and adds lane count, an operation select, accumulate mode and overflow flags. Valid/ready streaming on both sides, with optional backpressure. It sits between the operand fetch stream and the writeback stream in the datapath.

Parameters:
DATAW, 32, lane width in bits, two's-complement signed, >=2
LANES, 4, number of independent lanes, >=1
PIPES, 2, number of register stages from input to output, 0..8
BACKPRESSURE, 1, 1 = honour ready_i; 0 = ready_i ignored and ready_o tied high

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
valid_i  in  1  input beat valid
ready_o  out  1  input beat accepted when valid_i && ready_o
op_i  in  2  00 ADD, 01 SUB, 10 ACC, 11 reserved (executes as ADD)
last_i  in  1  ACC only: closes the accumulation and emits the result
dataa_i  in  LANES*DATAW  operand A, lane k at bits [k*DATAW +: DATAW]
datab_i  in  LANES*DATAW  operand B, ignored in ACC
valid_o  out  1  output beat valid
ready_i  in  1  downstream ready
sum_o  out  LANES*DATAW  per-lane result
ovf_o  out  LANES  per-lane signed overflow of the emitted result

Behaviour:
- Clock and reset: clk; rst_n is asynchronous, active-high.
- Reset values: valid_o=0, sum_o=0, ovf_o=0, every stage valid bit=0, all accumulators=0.
- ready_o is 1 during reset deassertion.
- Reset mid-operation discards in-flight beats and partial accumulations.
- Handshake: a beat is accepted on a clk edge with valid_i && ready_o. Output transfers when valid_o && ready_i.
- While valid_o && !ready_i, sum_o and ovf_o are held stable.
- Pipeline: the result is computed combinationally at input, then passes through PIPES stages, so latency = PIPES cycles.
- Each stage advances when it is empty or when its downstream stage advances. This is a bubble-collapsing stall.
- ready_o = !valid_s0 || stage0_advances, a combinational chain back from ready_i.
- PIPES=0: fully combinational. valid_o=valid_i, ready_o=ready_i, sum_o is the combinational result.
- Throughput: 1 beat/cycle with ready_i held high, with no bubbles inserted.
- BACKPRESSURE=0: every stage advances every cycle, ready_o=1, and ready_i is ignored.
- ADD: lane = a+b. SUB: lane = a-b. Result is truncated to DATAW bits (wrap).
- ovf_o[k] = 1 when the result's sign is inconsistent with the operand signs (standard two's-complement rule).
- ACC, per lane: sum = acc + a.
  - last_i=0: acc <= sum on acceptance. No output beat is generated; the beat is consumed and produces a bubble.
  - last_i=1: the output beat carries sum, and acc <= 0 on acceptance.
  - ovf_o reports overflow of the final addition only.
- Overflow in non-last ACC beats sets a sticky per-lane flag. The flag is ORed into ovf_o of the closing beat and cleared with the accumulator.
- Accumulator persists across interleaved ADD/SUB beats. ADD/SUB never modify acc.
- A single ACC beat with last_i=1 and acc=0 outputs a (+0).
- All lanes share valid/ready and operate in lockstep.

Optional Feature:
- Macro: VEC_ADD_ACC_SATURATE_EN.
- Defined: on overflow a lane result clamps to +2^(DATAW-1)-1 (positive overflow) or -2^(DATAW-1) (negative overflow).
  - The clamped value is also what is stored into acc.
  - ovf_o behaviour is unchanged.
- Undefined: wrap-around results, as described in Behaviour.

Test Plan:
- ADD streaming: DATAW=8, LANES=2, PIPES=2, ready_i=1; beats (3,4),(-5,2) every cycle -> sums 7,-3 appear 2 cycles after acceptance, back-to-back, ovf_o=0.
- Overflow: ADD 100+100 at DATAW=8 -> sum=-56, ovf_o=1. With VEC_ADD_ACC_SATURATE_EN -> 127, ovf_o=1. SUB -128-1 -> 127 (wrap) / -128 (sat), ovf_o=1.
- Accumulate: ACC a=10,20,30 with last_i on the third beat -> exactly one output beat 60. The next ACC last beat with a=5 -> 5, proving acc was cleared.
- Backpressure: BACKPRESSURE=1, PIPES=3, ready_i=0 for 5 cycles during a 6-beat burst.
  - ready_o drops once all 3 stages are full.
  - sum_o stays stable while stalled.
  - All 6 results arrive in order, with none lost or duplicated.
- Interleave and reset: ACC a=7 (no last), then ADD 1+1 -> output 2; then ACC last a=3 -> 10. Repeat, asserting rst_n between the ACC beats -> the closing beat outputs 3, and valid_o=0 immediately on reset.
- PIPES=0 and BACKPRESSURE=0 configurations: random 1000-beat run against the reference model, with random valid_i and ready_i -> all results match; ready_o tracks ready_i, or is constant 1 when BACKPRESSURE=0.

Source files
------------

// File: rtl/vec_add_acc.sv
// -----------------------------------------------------------------------------
// vec_add_acc: multi-lane pipelined signed adder/subtractor with a per-lane
// running accumulator, valid/ready on both sides.
//
// Optional build macro: VEC_ADD_ACC_SATURATE_EN
//   defined   -> overflowing lane results clamp to the signed max/min, and the
//                clamped value is what lands in the accumulator
//   undefined -> results wrap modulo 2^DATAW
//
// Parameters
//   DATAW        lane width (two's complement, >= 2)
//   LANES        number of lanes sharing one handshake
//   PIPES        register stages between input and output (0 = combinational)
//   BACKPRESSURE 1 = honour ready_i, 0 = ready_i ignored, ready_o tied high
//
// Ports
//   clk, rst_n         clock; asynchronous, active-HIGH reset
//   valid_i / ready_o  input handshake (ready_o is combinational)
//   op_i               00 ADD, 01 SUB, 10 ACC, 11 behaves as ADD
//   last_i             ACC only: close the accumulation and emit the result
//   dataa_i, datab_i   operands, lane k at [k*DATAW +: DATAW]
//   valid_o / ready_i  output handshake
//   sum_o, ovf_o       per-lane result and signed-overflow flag
// -----------------------------------------------------------------------------
module vec_add_acc #(
    parameter int unsigned DATAW        = 32,
    parameter int unsigned LANES        = 4,
    parameter int unsigned PIPES        = 2,
    parameter int unsigned BACKPRESSURE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [1:0]             op_i,
    input  logic                   last_i,
    input  logic [LANES*DATAW-1:0] dataa_i,
    input  logic [LANES*DATAW-1:0] datab_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [LANES*DATAW-1:0] sum_o,
    output logic [LANES-1:0]       ovf_o
);

    localparam int unsigned VW = LANES * DATAW;

`ifdef VEC_ADD_ACC_SATURATE_EN
    localparam logic [DATAW-1:0] SMAX = {1'b0, {(DATAW-1){1'b1}}};
    localparam logic [DATAW-1:0] SMIN = {1'b1, {(DATAW-1){1'b0}}};
`endif

    // Operation decode
    logic is_sub_c;
    logic is_acc_c;
    logic emit_c;
    logic fire_c;

    assign is_sub_c = (op_i == 2'b01);
    assign is_acc_c = (op_i == 2'b10);
    // A non-closing ACC beat is consumed without producing an output beat
    assign emit_c   = !is_acc_c || last_i;
    assign fire_c   = valid_i && ready_o;

    logic [VW-1:0]    acc_q;
    logic [VW-1:0]    acc_d;
    logic [LANES-1:0] sticky_q;
    logic [LANES-1:0] sticky_d;
    logic [VW-1:0]    sum_c;
    logic [LANES-1:0] ovf_c;
    logic [LANES-1:0] ovf_out_c;

    // Per-lane arithmetic; in ACC the accumulator takes the place of operand A
    always_comb begin : lane_calc
        logic [DATAW-1:0] x;
        logic [DATAW-1:0] y;
        logic [DATAW-1:0] r;
        logic             o;
        sum_c = '0;
        ovf_c = '0;
        x     = '0;
        y     = '0;
        r     = '0;
        o     = 1'b0;
        for (int k = 0; k < int'(LANES); k++) begin
            x = is_acc_c ? acc_q[k*DATAW +: DATAW] : dataa_i[k*DATAW +: DATAW];
            y = is_acc_c ? dataa_i[k*DATAW +: DATAW] : datab_i[k*DATAW +: DATAW];
            r = is_sub_c ? (x - y) : (x + y);
            // Overflow: result sign disagrees with x where x and (+/-)y agree
            if (is_sub_c) begin
                o = (x[DATAW-1] != y[DATAW-1]) && (r[DATAW-1] != x[DATAW-1]);
            end else begin
                o = (x[DATAW-1] == y[DATAW-1]) && (r[DATAW-1] != x[DATAW-1]);
            end
`ifdef VEC_ADD_ACC_SATURATE_EN
            // On overflow the true result lies on the side of x's sign
            if (o) begin
                r = x[DATAW-1] ? SMIN : SMAX;
            end
`endif
            sum_c[k*DATAW +: DATAW] = r;
            ovf_c[k]                = o;
        end
    end

    // The closing ACC beat also reports overflow seen earlier in the run
    assign ovf_out_c = ovf_c | (is_acc_c ? sticky_q : '0);

    // Accumulator and sticky overflow next state; ADD/SUB leave them alone
    always_comb begin
        acc_d    = acc_q;
        sticky_d = sticky_q;
        if (fire_c && is_acc_c) begin
            if (last_i) begin
                acc_d    = '0;
                sticky_d = '0;
            end else begin
                acc_d    = sum_c;
                sticky_d = sticky_q | ovf_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc_q    <= '0;
            sticky_q <= '0;
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
        end
    end

    generate
        if (PIPES == 0) begin : g_comb
            // Pass-through: the handshake and result are purely combinational
            assign ready_o = (BACKPRESSURE != 0) ? ready_i : 1'b1;
            assign valid_o = valid_i && emit_c && !rst_n;
            assign sum_o   = sum_c;
            assign ovf_o   = ovf_out_c;
        end else begin : g_pipe
            logic [PIPES-1:0]            vld_q;
            logic [PIPES-1:0]            adv_c;
            logic [PIPES-1:0]            up_vld_c;
            logic [PIPES-1:0][VW-1:0]    sum_q;
            logic [PIPES-1:0][VW-1:0]    up_sum_c;
            logic [PIPES-1:0][LANES-1:0] ovf_q;
            logic [PIPES-1:0][LANES-1:0] up_ovf_c;

            // Stage i advances if it, or any stage after it, has a hole,
            // or the consumer takes the last stage (bubble collapsing)
            always_comb begin : adv_chain
                logic ok;
                ok    = (BACKPRESSURE != 0) ? ready_i : 1'b1;
                adv_c = '0;
                for (int i = int'(PIPES) - 1; i >= 0; i--) begin
                    ok       = ok || !vld_q[i];
                    adv_c[i] = ok;
                end
            end

            // What each stage would load: head takes the fresh result
            always_comb begin
                up_vld_c    = '0;
                up_sum_c    = '0;
                up_ovf_c    = '0;
                up_vld_c[0] = fire_c && emit_c;
                up_sum_c[0] = sum_c;
                up_ovf_c[0] = ovf_out_c;
                for (int i = 1; i < int'(PIPES); i++) begin
                    up_vld_c[i] = vld_q[i-1];
                    up_sum_c[i] = sum_q[i-1];
                    up_ovf_c[i] = ovf_q[i-1];
                end
            end

            // Payload only moves with a valid beat so a drained stage keeps its data
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    vld_q <= '0;
                    sum_q <= '0;
                    ovf_q <= '0;
                end else begin
                    for (int i = 0; i < int'(PIPES); i++) begin
                        if (adv_c[i]) begin
                            vld_q[i] <= up_vld_c[i];
                            if (up_vld_c[i]) begin
                                sum_q[i] <= up_sum_c[i];
                                ovf_q[i] <= up_ovf_c[i];
                            end
                        end
                    end
                end
            end

            assign ready_o = adv_c[0];
            assign valid_o = vld_q[PIPES-1];
            assign sum_o   = sum_q[PIPES-1];
            assign ovf_o   = ovf_q[PIPES-1];
        end
    endgenerate

endmodule

// File: tb/tb_vec_add_acc.sv
// -----------------------------------------------------------------------------
// tb_vec_add_acc: checks vec_add_acc at DATAW=8, LANES=2 in three builds:
//   cfg0 PIPES=3 BACKPRESSURE=1, cfg1 PIPES=0 BACKPRESSURE=1,
//   cfg2 PIPES=2 BACKPRESSURE=0.
// Each build has an arithmetic model (plain integer maths with range checks)
// feeding an expected-result queue, plus directed beats with literal results.
// Honours VEC_ADD_ACC_SATURATE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_vec_add_acc;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i [NI];
    logic        ready_o [NI];
    logic [1:0]  op_i    [NI];
    logic        last_i  [NI];
    logic [15:0] a_i     [NI];
    logic [15:0] b_i     [NI];
    logic        valid_o [NI];
    logic        ready_i [NI];
    logic [15:0] sum_o   [NI];
    logic [1:0]  ovf_o   [NI];
    logic        done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no event, expected one", nm);
    endtask

    // Reference arithmetic: exact integer result, then range-check and wrap/clamp
    function automatic void model_step(
        input  logic [1:0]  op,
        input  logic        last,
        input  logic [15:0] a,
        input  logic [15:0] b,
        input  logic [15:0] acc_in,
        input  logic [1:0]  st_in,
        output logic        emit,
        output logic [15:0] res,
        output logic [1:0]  ovf,
        output logic [15:0] acc_out,
        output logic [1:0]  st_out
    );
        logic [7:0] xa, xb, xc;
        int         t, r;
        logic       o;
        emit    = !(op == 2'b10 && !last);
        res     = '0;
        ovf     = '0;
        acc_out = acc_in;
        st_out  = st_in;
        for (int k = 0; k < 2; k++) begin
            xa = a[k*8 +: 8];
            xb = b[k*8 +: 8];
            xc = acc_in[k*8 +: 8];
            case (op)
                2'b01:   t = int'($signed(xa)) - int'($signed(xb));
                2'b10:   t = int'($signed(xc)) + int'($signed(xa));
                default: t = int'($signed(xa)) + int'($signed(xb));
            endcase
            o = (t > 127) || (t < -128);
            r = t;
`ifdef VEC_ADD_ACC_SATURATE_EN
            if (t > 127) r = 127;
            else if (t < -128) r = -128;
`endif
            res[k*8 +: 8] = 8'(r);
            ovf[k]        = o;
            if (op == 2'b10) begin
                if (last) begin
                    ovf[k]            = o | st_in[k];
                    acc_out[k*8 +: 8] = 8'h00;
                    st_out[k]         = 1'b0;
                end else begin
                    acc_out[k*8 +: 8] = 8'(r);
                    st_out[k]         = st_in[k] | o;
                end
            end
        end
    endfunction

    for (genvar g = 0; g < NI; g++) begin : cfg
        localparam bit BP_G  = (g != 2);
        localparam bit REG_G = (g != 1);

        vec_add_acc #(
            .DATAW        (8),
            .LANES        (2),
            .PIPES        ((g == 0) ? 3 : ((g == 1) ? 0 : 2)),
            .BACKPRESSURE ((g == 2) ? 0 : 1)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (valid_i[g]),
            .ready_o (ready_o[g]),
            .op_i    (op_i[g]),
            .last_i  (last_i[g]),
            .dataa_i (a_i[g]),
            .datab_i (b_i[g]),
            .valid_o (valid_o[g]),
            .ready_i (ready_i[g]),
            .sum_o   (sum_o[g]),
            .ovf_o   (ovf_o[g])
        );

        logic [15:0] q_sum [$];
        logic [1:0]  q_ovf [$];
        logic [15:0] m_acc    = '0;
        logic [1:0]  m_sticky = '0;
        logic        stalled  = 1'b0;
        logic [15:0] held_sum = '0;
        logic [1:0]  held_ovf = '0;

        // Sampled 1 time unit before each rising edge
        always begin : mon
            logic        emit, xfer;
            logic [15:0] r, na;
            logic [1:0]  o, ns;
            @(negedge clk);
            #4;
            if (rst_n) begin
                q_sum.delete();
                q_ovf.delete();
                m_acc    = '0;
                m_sticky = '0;
                stalled  = 1'b0;
            end else begin
                if (valid_i[g] && ready_o[g]) begin
                    model_step(op_i[g], last_i[g], a_i[g], b_i[g], m_acc, m_sticky,
                               emit, r, o, na, ns);
                    m_acc    = na;
                    m_sticky = ns;
                    if (emit) begin
                        q_sum.push_back(r);
                        q_ovf.push_back(o);
                    end
                end
                if (stalled) begin
                    chk($sformatf("cfg%0d held valid_o", g), 32'(valid_o[g]), 32'(1));
                    chk($sformatf("cfg%0d held sum_o", g), 32'(sum_o[g]), 32'(held_sum));
                    chk($sformatf("cfg%0d held ovf_o", g), 32'(ovf_o[g]), 32'(held_ovf));
                end
                xfer = valid_o[g] && (ready_i[g] || !BP_G);
                if (xfer) begin
                    if (q_sum.size() == 0) begin
                        fail($sformatf("cfg%0d unexpected output beat", g));
                    end else begin
                        chk($sformatf("cfg%0d sum_o", g), 32'(sum_o[g]), 32'(q_sum.pop_front()));
                        chk($sformatf("cfg%0d ovf_o", g), 32'(ovf_o[g]), 32'(q_ovf.pop_front()));
                    end
                end
                stalled  = REG_G && valid_o[g] && !xfer;
                held_sum = sum_o[g];
                held_ovf = ovf_o[g];
            end
        end

        if (g != 0) begin : g_rdy
            always begin
                @(negedge clk);
                #4;
                chk($sformatf("cfg%0d ready_o", g), 32'(ready_o[g]),
                    32'(BP_G ? ready_i[g] : 1'b1));
            end
        end

        initial begin
            wait (done);
            chk($sformatf("cfg%0d beats never delivered", g), 32'(q_sum.size()), 32'(0));
        end
    end

    // Present a beat at a falling edge and hold it until accepted
    task automatic send(input int g, input logic [1:0] op, input logic last,
                        input logic [15:0] a, input logic [15:0] b);
        valid_i[g] = 1'b1;
        op_i[g]    = op;
        last_i[g]  = last;
        a_i[g]     = a;
        b_i[g]     = b;
        for (int i = 0; i < 100; i++) begin
            #4;
            if (ready_o[g]) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        fail($sformatf("cfg%0d accept timeout", g));
    endtask

    task automatic idle(input int g);
        valid_i[g] = 1'b0;
        last_i[g]  = 1'b0;
    endtask

    // Wait for the next delivered beat and pin it to a literal value
    task automatic expect_out(input int g, input string nm,
                              input logic [15:0] es, input logic [1:0] eo);
        for (int i = 0; i < 30; i++) begin
            #4;
            if (valid_o[g] && ready_i[g]) begin
                chk({nm, " sum"}, 32'(sum_o[g]), 32'(es));
                chk({nm, " ovf"}, 32'(ovf_o[g]), 32'(eo));
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        fail({nm, " timeout"});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        for (int g = 0; g < NI; g++) begin
            valid_i[g] = 1'b0;
            ready_i[g] = 1'b1;
            op_i[g]    = 2'b00;
            last_i[g]  = 1'b0;
            a_i[g]     = '0;
            b_i[g]     = '0;
        end
        repeat (3) @(negedge clk);
        #4;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("cfg%0d reset valid_o", g), 32'(valid_o[g]), 32'(0));
            chk($sformatf("cfg%0d reset sum_o", g), 32'(sum_o[g]), 32'(0));
            chk($sformatf("cfg%0d reset ovf_o", g), 32'(ovf_o[g]), 32'(0));
            chk($sformatf("cfg%0d reset ready_o", g), 32'(ready_o[g]), 32'(1));
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);

        // Back-to-back ADD on the 2-stage build: lanes (3+4, 10-20), (-5+2, 0+0)
        send(2, 2'b00, 1'b0, 16'h0A03, 16'hEC04);
        send(2, 2'b00, 1'b0, 16'h00FB, 16'h0002);
        idle(2);
        #4;
        chk("stream beat1 valid", 32'(valid_o[2]), 32'(1));
        chk("stream beat1 sum", 32'(sum_o[2]), 32'(16'hF607));
        chk("stream beat1 ovf", 32'(ovf_o[2]), 32'(0));
        @(negedge clk);
        #4;
        chk("stream beat2 valid", 32'(valid_o[2]), 32'(1));
        chk("stream beat2 sum", 32'(sum_o[2]), 32'(16'h00FD));
        @(negedge clk);
        #4;
        chk("stream after valid", 32'(valid_o[2]), 32'(0));
        @(negedge clk);

        // Overflow: 100+100 and -128-1 in lane 0
        send(0, 2'b00, 1'b0, 16'h0164, 16'h0264);
        send(0, 2'b01, 1'b0, 16'h0580, 16'h0701);
        idle(0);
`ifdef VEC_ADD_ACC_SATURATE_EN
        expect_out(0, "ovf add", 16'h037F, 2'b01);
        expect_out(0, "ovf sub", 16'hFE80, 2'b01);
`else
        expect_out(0, "ovf add", 16'h03C8, 2'b01);
        expect_out(0, "ovf sub", 16'hFE7F, 2'b01);
`endif

        // Accumulate 10,20,30 (lane 1: -1,-2,-3), then a fresh run of 5
        send(0, 2'b10, 1'b0, 16'hFF0A, 16'h5555);
        send(0, 2'b10, 1'b0, 16'hFE14, 16'h5555);
        send(0, 2'b10, 1'b1, 16'hFD1E, 16'h5555);
        idle(0);
        expect_out(0, "acc 60", 16'hFA3C, 2'b00);
        send(0, 2'b10, 1'b1, 16'h0005, 16'h0000);
        idle(0);
        expect_out(0, "acc cleared", 16'h0005, 2'b00);

        // ADD between ACC beats leaves the accumulator intact
        send(0, 2'b10, 1'b0, 16'h0007, 16'h0000);
        send(0, 2'b00, 1'b0, 16'h0001, 16'h0001);
        send(0, 2'b10, 1'b1, 16'h0003, 16'h0000);
        idle(0);
        expect_out(0, "interleave add", 16'h0002, 2'b00);
        expect_out(0, "interleave acc", 16'h000A, 2'b00);

        // Same again with a reset between the ACC beats and a beat in flight
        send(0, 2'b10, 1'b0, 16'h0007, 16'h0000);
        ready_i[0] = 1'b0;
        send(0, 2'b00, 1'b0, 16'h0001, 16'h0001);
        idle(0);
        repeat (3) @(negedge clk);
        #1;
        chk("pre-reset in flight valid", 32'(valid_o[0]), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset kills valid_o", 32'(valid_o[0]), 32'(0));
        chk("reset clears sum_o", 32'(sum_o[0]), 32'(0));
        @(negedge clk);
        rst_n      = 1'b0;
        ready_i[0] = 1'b1;
        send(0, 2'b10, 1'b1, 16'h0003, 16'h0000);
        idle(0);
        expect_out(0, "acc after reset", 16'h0003, 2'b00);

        // 6-beat burst into the 3-stage build with the consumer stalled 5 cycles
        ready_i[0] = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(0, 2'b00, 1'b0, {8'(i), 8'(i * 10)}, 16'h0102);
                end
                idle(0);
            end
            begin
                repeat (4) @(negedge clk);
                #4;
                chk("bp ready_o low when full", 32'(ready_o[0]), 32'(0));
                @(negedge clk);
                ready_i[0] = 1'b1;
            end
        join
        repeat (10) @(negedge clk);

        // Random traffic on the combinational and no-backpressure builds
        for (int c = 0; c < 2500; c++) begin
            for (int g = 1; g < NI; g++) begin
                valid_i[g] = ($urandom_range(0, 3) != 0);
                ready_i[g] = ($urandom_range(0, 3) != 0);
                op_i[g]    = 2'($urandom_range(0, 3));
                last_i[g]  = ($urandom_range(0, 2) == 0);
                a_i[g]     = 16'($urandom);
                b_i[g]     = 16'($urandom);
            end
            @(negedge clk);
        end
        for (int g = 1; g < NI; g++) begin
            valid_i[g] = 1'b0;
            ready_i[g] = 1'b1;
        end
        repeat (10) @(negedge clk);

        done = 1'b1;
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
